// File: rtl/axil_m_arbiter.sv
// Two-requester round-robin arbiter feeding one AXI-Lite master port, one transaction in flight.
// Latency: accept edge T0, AW/W or AR handshake T1, B/R handshake T2, rsp_valid high T2-T3 (zero-wait slave).
// Backpressure: req_ready only in IDLE; AXI valids hold with stable payload until their ready; no retry/timeout.
module axil_m_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        axi_clk,
    input  logic                        axi_reset,
    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  logic [1:0]                  req_wr,
    input  logic [2*ADDR_WIDTH-1:0]     req_addr,
    input  logic [2*DATA_WIDTH-1:0]     req_wdata,
    input  logic [2*DATA_WIDTH/8-1:0]   req_wstrb,
    output logic [1:0]                  rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
    output logic [1:0]                  rsp_resp,
    output logic                        m_awvalid,
    input  logic                        m_awready,
    output logic [ADDR_WIDTH-1:0]       m_awaddr,
    output logic                        m_wvalid,
    input  logic                        m_wready,
    output logic [DATA_WIDTH-1:0]       m_wdata,
    output logic [DATA_WIDTH/8-1:0]     m_wstrb,
    input  logic                        m_bvalid,
    output logic                        m_bready,
    input  logic [1:0]                  m_bresp,
    output logic                        m_arvalid,
    input  logic                        m_arready,
    output logic [ADDR_WIDTH-1:0]       m_araddr,
    input  logic                        m_rvalid,
    output logic                        m_rready,
    input  logic [DATA_WIDTH-1:0]       m_rdata,
    input  logic [1:0]                  m_rresp
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, DONE} state_t;

    state_t                  state;
    logic                    last_grant;
    logic                    owner;
    logic                    aw_done;
    logic                    w_done;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   wstrb_q;

    logic grant_sel;
    logic accept;
    logic aw_hs;
    logic w_hs;
    logic aw_done_n;
    logic w_done_n;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant_sel = req_valid[1];
        if (req_valid == 2'b11) grant_sel = ~last_grant;
        req_ready = 2'b00;
        if (state == IDLE && req_valid != 2'b00) req_ready = grant_sel ? 2'b10 : 2'b01;
    end

    assign accept    = |req_ready;
    assign aw_hs     = m_awvalid & m_awready;
    assign w_hs      = m_wvalid & m_wready;
    assign aw_done_n = aw_done | aw_hs;
    assign w_done_n  = w_done | w_hs;

    assign m_awaddr = addr_q;
    assign m_araddr = addr_q;
    assign m_wdata  = wdata_q;
    assign m_wstrb  = wstrb_q;

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            m_awvalid  <= 1'b0;
            m_wvalid   <= 1'b0;
            m_bready   <= 1'b0;
            m_arvalid  <= 1'b0;
            m_rready   <= 1'b0;
            rsp_valid  <= 2'b00;
            rsp_rdata  <= '0;
            rsp_resp   <= 2'b00;
        end else begin
            rsp_valid <= 2'b00;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner      <= grant_sel;
                        last_grant <= grant_sel;
                        addr_q     <= grant_sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
                        wdata_q    <= grant_sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
                        wstrb_q    <= grant_sel ? req_wstrb[2*STRB_WIDTH-1:STRB_WIDTH] : req_wstrb[STRB_WIDTH-1:0];
                        if (req_wr[grant_sel]) begin
                            m_awvalid <= 1'b1;
                            m_wvalid  <= 1'b1;
                            state     <= WR_REQ;
                        end else begin
                            m_arvalid <= 1'b1;
                            state     <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    // AW and W retire independently; move on once both have.
                    if (aw_hs) m_awvalid <= 1'b0;
                    if (w_hs)  m_wvalid  <= 1'b0;
                    if (aw_done_n && w_done_n) begin
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                        m_bready <= 1'b1;
                        state    <= WR_RSP;
                    end else begin
                        aw_done <= aw_done_n;
                        w_done  <= w_done_n;
                    end
                end
                WR_RSP: begin
                    if (m_bvalid) begin
                        m_bready  <= 1'b0;
                        rsp_resp  <= m_bresp;
                        rsp_rdata <= '0;
                        rsp_valid <= {owner, ~owner};
                        state     <= DONE;
                    end
                end
                RD_REQ: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        state     <= RD_RSP;
                    end
                end
                RD_RSP: begin
                    if (m_rvalid) begin
                        m_rready  <= 1'b0;
                        rsp_resp  <= m_rresp;
                        rsp_rdata <= m_rdata;
                        rsp_valid <= {owner, ~owner};
                        state     <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_m_arbiter.sv
// Directed bench for axil_m_arbiter: single write/read, fairness, skewed handshakes, error pass-through, reset.
module tb_axil_m_arbiter;
    localparam int AW = 15;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              axi_clk = 1'b0;
    logic              axi_reset;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_wr;
    logic [2*AW-1:0]   req_addr;
    logic [2*DW-1:0]   req_wdata;
    logic [2*SW-1:0]   req_wstrb;
    logic [1:0]        rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic [1:0]        rsp_resp;
    logic              m_awvalid, m_awready;
    logic [AW-1:0]     m_awaddr;
    logic              m_wvalid, m_wready;
    logic [DW-1:0]     m_wdata;
    logic [SW-1:0]     m_wstrb;
    logic              m_bvalid, m_bready;
    logic [1:0]        m_bresp;
    logic              m_arvalid, m_arready;
    logic [AW-1:0]     m_araddr;
    logic              m_rvalid, m_rready;
    logic [DW-1:0]     m_rdata;
    logic [1:0]        m_rresp;

    int checks = 0;
    int failures = 0;

    // Results captured by the zero-wait slave driver.
    logic [1:0]    sv_owner;
    logic [DW-1:0] sv_rdata;
    logic [1:0]    sv_resp;
    logic [AW-1:0] sv_addr;
    logic [DW-1:0] sv_wdata;
    logic [SW-1:0] sv_wstrb;
    int            sv_lat;
    int            sv_hs;
    bit            sv_timeout;

    axil_m_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .axi_clk(axi_clk), .axi_reset(axi_reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
    );

    always #5 axi_clk = ~axi_clk;

    task automatic tick;
        @(posedge axi_clk);
        #1;
    endtask

    // Zero-wait slave: readies held by caller, B/R valid raised in the cycle the DUT waits for them.
    task automatic serve(input bit drop);
        int acc_at;
        bit acc;
        acc_at = 0;
        sv_owner = 2'b00; sv_rdata = '0; sv_resp = 2'b00; sv_addr = '0;
        sv_wdata = '0; sv_wstrb = '0; sv_lat = -1; sv_hs = 0; sv_timeout = 1'b1;
        for (int c = 0; c < 20; c++) begin
            m_bvalid = m_bready;
            m_rvalid = m_rready;
            #1;
            acc = |req_ready;
            if (acc) acc_at = c;
            if (m_awvalid && m_awready) begin
                sv_hs++; sv_addr = m_awaddr; sv_wdata = m_wdata; sv_wstrb = m_wstrb;
            end
            if (m_arvalid && m_arready) begin
                sv_hs++; sv_addr = m_araddr;
            end
            tick();
            if (acc && drop) req_valid = 2'b00;
            if (rsp_valid != 2'b00) begin
                sv_owner = rsp_valid; sv_rdata = rsp_rdata; sv_resp = rsp_resp;
                sv_lat = c - acc_at; sv_timeout = 1'b0;
                break;
            end
        end
        m_bvalid = 1'b0;
        m_rvalid = 1'b0;
    endtask

    task automatic test_reset;
        axi_reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 5'b0) begin
            failures++; $display("FAIL reset_axi_ctrl got=%b exp=00000", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
        end
        checks++;
        if ({rsp_valid, rsp_resp, rsp_rdata, req_ready} !== '0) begin
            failures++; $display("FAIL reset_rsp got valid=%b resp=%b rdata=%h ready=%b exp all 0", rsp_valid, rsp_resp, rsp_rdata, req_ready);
        end
        checks++;
        if ({m_awaddr, m_wdata, m_wstrb} !== '0) begin
            failures++; $display("FAIL reset_payload got addr=%h data=%h strb=%h exp 0", m_awaddr, m_wdata, m_wstrb);
        end
        axi_reset = 1'b0;
        tick();
    endtask

    task automatic test_single_write;
        m_awready = 1; m_wready = 1; m_arready = 1; m_bresp = 2'b00;
        req_wr = 2'b01;
        req_addr[AW-1:0] = 15'h0010;
        req_wdata[DW-1:0] = 32'hDEADBEEF;
        req_wstrb[SW-1:0] = 4'hF;
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin failures++; $display("FAIL wr_req_ready got=%b exp=01", req_ready); end
        serve(1'b1);
        checks++;
        if (sv_timeout) begin failures++; $display("FAIL wr_timeout got=no_rsp exp=rsp"); end
        checks++;
        if ({sv_addr, sv_wdata, sv_wstrb} !== {15'h0010, 32'hDEADBEEF, 4'hF}) begin
            failures++; $display("FAIL wr_beat got addr=%h data=%h strb=%h exp 0010 deadbeef f", sv_addr, sv_wdata, sv_wstrb);
        end
        checks++;
        if (sv_owner !== 2'b01 || sv_lat !== 2) begin
            failures++; $display("FAIL wr_rsp got owner=%b lat=%0d exp owner=01 lat=2", sv_owner, sv_lat);
        end
        checks++;
        if (sv_resp !== 2'b00 || sv_rdata !== 32'h0) begin
            failures++; $display("FAIL wr_resp got resp=%b rdata=%h exp 00 0", sv_resp, sv_rdata);
        end
    endtask

    task automatic test_single_read;
        m_rdata = 32'h12345678; m_rresp = 2'b00;
        req_wr = 2'b00;
        req_addr[2*AW-1:AW] = 15'h0124;
        req_valid = 2'b10;
        serve(1'b1);
        checks++;
        if (sv_timeout || sv_owner !== 2'b10) begin
            failures++; $display("FAIL rd_owner got=%b timeout=%0d exp=10", sv_owner, sv_timeout);
        end
        checks++;
        if (sv_addr !== 15'h0124 || sv_rdata !== 32'h12345678 || sv_resp !== 2'b00) begin
            failures++; $display("FAIL rd_data got addr=%h rdata=%h resp=%b exp 0124 12345678 00", sv_addr, sv_rdata, sv_resp);
        end
        tick();
        checks++;
        if (rsp_valid !== 2'b00 || rsp_rdata !== 32'h12345678) begin
            failures++; $display("FAIL rd_pulse_hold got valid=%b rdata=%h exp 00 12345678", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_fairness;
        logic [1:0] exp_owner;
        req_wr = 2'b01;
        req_addr = {15'h0300, 15'h0200};
        m_rdata = 32'h0000_5555;
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            exp_owner = (i % 2 == 0) ? 2'b01 : 2'b10;
            serve(1'b0);
            checks++;
            if (sv_timeout || sv_owner !== exp_owner || sv_hs !== 1 || sv_lat !== 2) begin
                failures++;
                $display("FAIL fair_%0d got owner=%b hs=%0d lat=%0d timeout=%0d exp owner=%b hs=1 lat=2",
                         i, sv_owner, sv_hs, sv_lat, sv_timeout, exp_owner);
            end
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_skewed;
        m_awready = 0; m_wready = 0; m_bresp = 2'b00;
        req_wr = 2'b11;
        req_addr = {15'h0444, 15'h0200};
        req_wdata = {32'h0BB0_0002, 32'hA5A5_0001};
        req_wstrb = {4'hC, 4'h3};
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        checks++;
        if ({m_awvalid, m_wvalid, m_bready} !== 3'b110) begin
            failures++; $display("FAIL skew_a_start got=%b exp=110", {m_awvalid, m_wvalid, m_bready});
        end
        m_wready = 1; tick(); m_wready = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({m_awvalid, m_wvalid, m_bready} !== 3'b100 || m_awaddr !== 15'h0200) begin
                failures++; $display("FAIL skew_a_stall%0d got ctl=%b addr=%h exp 100 0200", i, {m_awvalid, m_wvalid, m_bready}, m_awaddr);
            end
            if (i < 2) tick();
        end
        m_awready = 1; tick(); m_awready = 0;
        checks++;
        if ({m_awvalid, m_wvalid, m_bready} !== 3'b001) begin
            failures++; $display("FAIL skew_a_bready got=%b exp=001", {m_awvalid, m_wvalid, m_bready});
        end
        m_bvalid = 1; tick(); m_bvalid = 0;
        checks++;
        if (rsp_valid !== 2'b01) begin failures++; $display("FAIL skew_a_rsp got=%b exp=01", rsp_valid); end
        req_valid = 2'b10;
        tick();
        checks++;
        if (req_ready !== 2'b10) begin failures++; $display("FAIL skew_b_ready got=%b exp=10", req_ready); end
        tick();
        req_valid = 2'b00;
        m_awready = 1; tick(); m_awready = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({m_awvalid, m_wvalid, m_bready} !== 3'b010 || m_wdata !== 32'h0BB0_0002 || m_wstrb !== 4'hC) begin
                failures++; $display("FAIL skew_b_stall%0d got ctl=%b data=%h strb=%h exp 010 0bb00002 c",
                                     i, {m_awvalid, m_wvalid, m_bready}, m_wdata, m_wstrb);
            end
            if (i < 2) tick();
        end
        m_wready = 1; tick(); m_wready = 0;
        checks++;
        if ({m_awvalid, m_wvalid, m_bready} !== 3'b001) begin
            failures++; $display("FAIL skew_b_bready got=%b exp=001", {m_awvalid, m_wvalid, m_bready});
        end
        m_bvalid = 1; tick(); m_bvalid = 0;
        checks++;
        if (rsp_valid !== 2'b10) begin failures++; $display("FAIL skew_b_rsp got=%b exp=10", rsp_valid); end
        tick();
    endtask

    task automatic test_error_resp;
        m_awready = 1; m_wready = 1; m_arready = 1;
        m_bresp = 2'b10;
        req_wr = 2'b10;
        req_valid = 2'b10;
        serve(1'b1);
        checks++;
        if (sv_timeout || sv_owner !== 2'b10 || sv_resp !== 2'b10) begin
            failures++; $display("FAIL err_bresp got owner=%b resp=%b exp 10 10", sv_owner, sv_resp);
        end
        tick();
        checks++;
        if (rsp_valid !== 2'b00) begin failures++; $display("FAIL err_b_pulse got=%b exp=00", rsp_valid); end
        m_rresp = 2'b11; m_rdata = 32'hCAFEF00D;
        req_wr = 2'b00;
        req_valid = 2'b01;
        serve(1'b1);
        checks++;
        if (sv_timeout || sv_owner !== 2'b01 || sv_resp !== 2'b11 || sv_rdata !== 32'hCAFEF00D) begin
            failures++; $display("FAIL err_rresp got owner=%b resp=%b rdata=%h exp 01 11 cafef00d", sv_owner, sv_resp, sv_rdata);
        end
        tick();
        checks++;
        if (rsp_valid !== 2'b00) begin failures++; $display("FAIL err_r_pulse got=%b exp=00", rsp_valid); end
        m_rresp = 2'b00;
    endtask

    task automatic test_reset_mid;
        m_arready = 1; m_rvalid = 0;
        req_wr = 2'b00;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        checks++;
        if (m_rready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_rd_rsp got rready=%b exp=1", m_rready); end
        axi_reset = 1'b1;
        #1;
        checks++;
        if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid} !== 7'b0) begin
            failures++; $display("FAIL rst_mid_clear got=%b exp=0", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid});
        end
        tick();
        axi_reset = 1'b0;
        tick();
        checks++;
        if (rsp_valid !== 2'b00) begin failures++; $display("FAIL rst_mid_no_rsp got=%b exp=00", rsp_valid); end
        req_addr = {15'h0777, 15'h0666};
        m_rdata = 32'h0BADF00D;
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin failures++; $display("FAIL rst_tie got=%b exp=01", req_ready); end
        serve(1'b1);
        checks++;
        if (sv_timeout || sv_owner !== 2'b01 || sv_addr !== 15'h0666 || sv_rdata !== 32'h0BADF00D) begin
            failures++; $display("FAIL rst_after_txn got owner=%b addr=%h rdata=%h exp 01 0666 0badf00d", sv_owner, sv_addr, sv_rdata);
        end
    endtask

    initial begin
        axi_reset = 1'b1;
        req_valid = 2'b00; req_wr = 2'b00; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 2'b00;
        m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = 2'b00;
        test_reset();
        test_single_write();
        test_single_read();
        test_fairness();
        test_skewed();
        test_error_resp();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
